// File: rtl/btn_pkg.sv
// Shared definitions for the button event arbiter: width helpers derived
// from the button count, event-code field positions and the auto-repeat
// FSM state encoding.
package btn_pkg;

    // Auto-repeat FSM states (one FSM per button, BTN_REPEAT_EN builds only).
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Width of a button index; at least one bit.
    function automatic int idx_w(input int n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

    // Event code width: {repeat_flag, btn_index}.
    function automatic int code_w(input int n_btn);
        return idx_w(n_btn) + 1;
    endfunction

    // Bit position of the repeat flag inside an event code (the MSB).
    function automatic int rpt_flag_pos(input int n_btn);
        return idx_w(n_btn);
    endfunction

    // Width of a tick counter able to reach the larger of two limits.
    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_event_arbiter_fifo.sv
// evt_fifo: small synchronous FIFO holding event codes between the arbiter
// and the consumer. Head data reads as zero while empty so the event code
// output is clean whenever nothing is queued.
module evt_fifo
    import btn_pkg::*;
#(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge sysclk) begin
        // NOTE: storage is not reset; stale entries are never visible because reads are gated by empty.
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: latches press pulses from N_BTN debouncers, grants
// pending buttons round-robin (one per cycle) into an event queue and hands
// {repeat_flag, btn_index} codes to a consumer over valid/ready. A press that
// arrives while the same button is still pending sets the sticky drop flag.
// Optional feature macro: BTN_REPEAT_EN adds per-button auto-repeat FSMs that
// turn held buttons into timed repeat events; without it btn_held and tick
// are ignored and the repeat flag is always 0.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter  int N_BTN      = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int RPT_DELAY  = 8,
    parameter  int RPT_PERIOD = 3,
    localparam int IW         = idx_w(N_BTN),
    localparam int CW         = code_w(N_BTN)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic [N_BTN-1:0] btn_held,
    input  logic             tick,
    output logic             evt_valid,
    output logic [CW-1:0]    evt_code,
    input  logic             evt_ready,
    output logic             evt_drop,
    input  logic             drop_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] gnt_onehot, press_gnt;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    gnt_idx, cand;
    logic             gnt_vld, gnt_is_rpt;
    logic             evt_drop_q, evt_drop_d;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count_unused;
    logic [CW-1:0]    push_code;

    assign gnt_onehot = N_BTN'(1) << gnt_idx;
    assign press_gnt  = (gnt_vld && !gnt_is_rpt) ? gnt_onehot : '0;
    assign push_code  = {gnt_is_rpt, gnt_idx};
    assign evt_valid  = ~fifo_empty;
    assign evt_drop   = evt_drop_q;

`ifdef BTN_REPEAT_EN
    localparam int CNTW = cnt_w(RPT_DELAY, RPT_PERIOD);

    rpt_state_e       rpt_state_q [N_BTN];
    rpt_state_e       rpt_state_d [N_BTN];
    logic [CNTW-1:0]  rpt_cnt_q   [N_BTN];
    logic [CNTW-1:0]  rpt_cnt_d   [N_BTN];
    logic [N_BTN-1:0] rpt_pending_q, rpt_pending_d;
    logic [N_BTN-1:0] rpt_gnt;

    assign req        = pending_q | rpt_pending_q;
    // A press and a repeat on the same index: the press goes first.
    assign gnt_is_rpt = gnt_vld & ~pending_q[gnt_idx];
    assign rpt_gnt    = gnt_is_rpt ? gnt_onehot : '0;

    // Repeat FSMs: count ticks while held, raise a repeat request on expiry;
    // a request already waiting absorbs a new one silently.
    always_comb begin
        rpt_pending_d = rpt_pending_q & ~rpt_gnt;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            if (!btn_held[i]) begin
                rpt_state_d[i]   = RPT_IDLE;
                rpt_cnt_d[i]     = '0;
                rpt_pending_d[i] = 1'b0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        rpt_state_d[i] = RPT_DELAY;
                        rpt_cnt_d[i]   = '0;
                    end
                    RPT_DELAY: begin
                        if (tick) begin
                            if (rpt_cnt_q[i] == CNTW'(RPT_DELAY - 1)) begin
                                rpt_pending_d[i] = 1'b1;
                                rpt_state_d[i]   = RPT_REPEAT;
                                rpt_cnt_d[i]     = '0;
                            end else begin
                                rpt_cnt_d[i] = rpt_cnt_q[i] + CNTW'(1);
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (tick) begin
                            if (rpt_cnt_q[i] == CNTW'(RPT_PERIOD - 1)) begin
                                rpt_pending_d[i] = 1'b1;
                                rpt_cnt_d[i]     = '0;
                            end else begin
                                rpt_cnt_d[i] = rpt_cnt_q[i] + CNTW'(1);
                            end
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Repeat FSM state, counters and repeat requests.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rpt_pending_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            rpt_pending_q <= rpt_pending_d;
            for (int i = 0; i < N_BTN; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
        end
    end
`else
    logic unused_repeat_inputs;

    assign req                  = pending_q;
    assign gnt_is_rpt           = 1'b0;
    assign unused_repeat_inputs = ^{btn_held, tick};
`endif

    // Round-robin search starting just after the last granted index; no
    // grant while the queue is full (registered occupancy, no pop bypass).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            cand = IW'((int'(rr_q) + k) % N_BTN);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (fifo_full) gnt_vld = 1'b0;
    end

    // Pending latches (a new press beats a same-cycle grant), round-robin
    // pointer update and sticky drop detection.
    always_comb begin
        pending_d  = btn_pulse | (pending_q & ~press_gnt);
        rr_d       = gnt_vld ? gnt_idx : rr_q;
        evt_drop_d = (evt_drop_q & ~drop_clr) | (|(btn_pulse & pending_q & ~press_gnt));
    end

    // Arbiter state registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            pending_q  <= '0;
            rr_q       <= IW'(N_BTN - 1);
            evt_drop_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            evt_drop_q <= evt_drop_d;
        end
    end

    evt_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .push_i  (gnt_vld),
        .pop_i   (evt_valid & evt_ready),
        .wdata_i (push_code),
        .rdata_o (evt_code),
        .count_o (fifo_count_unused),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
